// File: rtl/npu_pkg.sv
// Shared types for the NPU stream tile: FSM state encoding and per-job configuration.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npu_pkg;

    localparam int NPU_SHIFT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Requantisation settings captured on the first beat of a job.
    typedef struct packed {
        logic [NPU_SHIFT_W-1:0] shift;
        logic                   relu_en;
    } job_cfg_t;

endpackage

// File: rtl/npu_ppu_lane.sv
// Post-processing lane: round-half-up arithmetic shift, optional ReLU, saturate to DATA_WIDTH.
// Latency: combinational.
// Backpressure: none; the output follows the registered accumulator it is fed.
module npu_ppu_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT_W    = 5
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [SHIFT_W-1:0]    shift_i,
    input  logic                         relu_en_i,
    output logic signed [DATA_WIDTH-1:0] res_o,
    output logic                         sat_o
);

    // Result limits expressed at the widened working precision.
    localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] MIN_V = ~MAX_V;

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] shifted;
    logic signed [ACC_WIDTH:0] clipped;

    // One extra bit of headroom keeps the rounding addend from overflowing a full-scale accumulator.
    always_comb begin
        ext = {acc_i[ACC_WIDTH-1], acc_i};
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (ACC_WIDTH+1)'(1) << (shift_i - SHIFT_W'(1));
        end
        sum     = ext + rnd;
        shifted = sum >>> shift_i;
        clipped = shifted;
        if (relu_en_i && shifted[ACC_WIDTH]) begin
            clipped = '0;
        end
        sat_o = 1'b0;
        res_o = clipped[DATA_WIDTH-1:0];
        if (clipped > MAX_V) begin
            res_o = MAX_V[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (clipped < MIN_V) begin
            res_o = MIN_V[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/npu_stream_tile.sv
// Outer-product INT8 matmul tile: accumulates A-column x B-row per beat, drains requantised C rows.
// Latency: first output row valid the cycle after the tlast beat; one row per cycle thereafter.
// Backpressure: input stalled (tready=0) while draining; output row held stable until m_axis_tready.
module npu_stream_tile
    import npu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT_W    = NPU_SHIFT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SHIFT_W-1:0]                cfg_shift,
    input  logic                              cfg_relu_en,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [(ROWS+COLS)*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [COLS*DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              done,
    output logic                              sat_flag
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t                 state_q;
    logic [RW-1:0]          row_idx_q;
    job_cfg_t               cfg_q;
    logic                   done_q;
    logic                   sat_q;

    logic                   in_rdy;
    logic                   out_vld;
    logic                   in_hs;
    logic                   out_hs;

    logic signed [ACC_WIDTH-1:0]  acc_w    [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] lane_res [COLS];
    logic [COLS-1:0]              lane_sat;
    logic [COLS*DATA_WIDTH-1:0]   row_dat;

    assign in_rdy  = !rst && (state_q != ST_DRAIN);
    assign out_vld = !rst && (state_q == ST_DRAIN);
    assign in_hs   = s_axis_tvalid && in_rdy;
    assign out_hs  = out_vld && m_axis_tready;

    // MAC array: one accumulator per C element; a beat taken in IDLE overwrites instead of adding.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic signed [DATA_WIDTH-1:0]   a_e;
            logic signed [DATA_WIDTH-1:0]   b_e;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0]    acc_d;
            logic signed [ACC_WIDTH-1:0]    acc_q;

            assign a_e   = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_e   = s_axis_tdata[(ROWS+gj)*DATA_WIDTH +: DATA_WIDTH];
            assign prod  = a_e * b_e;
            assign acc_d = ((state_q == ST_IDLE) ? '0 : acc_q) + ACC_WIDTH'(prod);

            // Accumulator update on every accepted input beat; wraps modulo 2^ACC_WIDTH.
            always_ff @(posedge clk) begin
                if (in_hs) begin
                    acc_q <= acc_d;
                end
            end

            assign acc_w[gi][gj] = acc_q;
        end
    end

    // Post-processing of the row currently being drained.
    for (genvar gj = 0; gj < COLS; gj++) begin : g_lane
        npu_ppu_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SHIFT_W    (SHIFT_W)
        ) u_lane (
            .acc_i      (acc_w[row_idx_q][gj]),
            .shift_i    (cfg_q.shift),
            .relu_en_i  (cfg_q.relu_en),
            .res_o      (lane_res[gj]),
            .sat_o      (lane_sat[gj])
        );
        assign row_dat[gj*DATA_WIDTH +: DATA_WIDTH] = lane_res[gj];
    end

    // Job sequencing: latch cfg on the first beat, drain rows, flag saturation on accepted rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_idx_q <= '0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_hs) begin
                        cfg_q.shift   <= cfg_shift;
                        cfg_q.relu_en <= cfg_relu_en;
                        state_q       <= s_axis_tlast ? ST_DRAIN : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_hs && s_axis_tlast) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        if (|lane_sat) begin
                            sat_q <= 1'b1;
                        end
                        if (row_idx_q == LAST_ROW) begin
                            row_idx_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            row_idx_q <= row_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_tready = in_rdy;
    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_vld ? row_dat : '0;
    assign m_axis_tlast  = out_vld && (row_idx_q == LAST_ROW);
    assign busy          = !rst && (state_q != ST_IDLE);
    assign done          = !rst && done_q;
    assign sat_flag      = !rst && sat_q;

endmodule

// File: tb/tb_npu_stream_tile.sv
// Scoreboard bench for npu_stream_tile: directed and randomized jobs against a behavioural model.
// Latency: n/a.
// Backpressure: random gaps on the input stream and random m_axis_tready on the output.
module tb_npu_stream_tile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_shift;
    logic        cfg_relu_en;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        sat_flag;

    npu_stream_tile #(
        .ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(24), .SHIFT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          rnd_ready  = 0;
    bit          hold_ready = 0;
    int          a_mem[512][4];
    int          b_mem[512][4];
    logic [31:0] dir_rows[4];
    bit          dir_sat[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint floordiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // Golden model: integer dot products, wrap to 24 bits, round-half-up divide, ReLU, clamp.
    task automatic push_model(input int k, input int sh, input bit relu);
        longint acc;
        longint num;
        longint r;
        exp_t   e;
        for (int i = 0; i < 4; i++) begin
            e.dat  = '0;
            e.sat  = 1'b0;
            e.last = (i == 3);
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int kk = 0; kk < k; kk++) acc += longint'(a_mem[kk][i]) * longint'(b_mem[kk][j]);
                acc = acc & 64'hFF_FFFF;
                if (acc >= 64'sd8388608) acc = acc - 64'sd16777216;
                num = acc + ((sh != 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
                r   = floordiv(num, 64'sd1 <<< sh);
                if (relu && r < 0) r = 0;
                if (r > 127)  begin r = 127;  e.sat = 1'b1; end
                if (r < -128) begin r = -128; e.sat = 1'b1; end
                e.dat[8*j +: 8] = 8'(r);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_dir();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.dat = dir_rows[i]; e.last = (i == 3); e.sat = dir_sat[i];
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [63:0] beat_dat(input int kk);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(a_mem[kk][i]);
        for (int j = 0; j < 4; j++) d[32+8*j +: 8] = 8'(b_mem[kk][j]);
        return d;
    endfunction

    // Present one beat and hold it until accepted; returns at posedge+1 after the transfer.
    task automatic send_beat(input logic [63:0] d, input bit l);
        int t;
        t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 3000) begin
                check("s_tready_timeout", 1, 0);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_job(input int k, input int sh, input bit relu, input bit gaps, input bit use_dir);
        if (use_dir) push_dir();
        else push_model(k, sh, relu);
        cfg_shift   = 5'(sh);
        cfg_relu_en = relu;
        for (int kk = 0; kk < k; kk++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(beat_dat(kk), kk == k - 1);
            // Scramble cfg after the job has latched it.
            cfg_shift   = 5'($urandom);
            cfg_relu_en = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) break;
            t++;
            if (t > 5000) begin
                check("drain_timeout", exp_q.size(), 0);
                break;
            end
        end
    endtask

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < 4; i++) begin
                a_mem[kk][i] = int'($urandom_range(0, 255)) - 128;
                b_mem[kk][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_const(input int k, input int a, input int b);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < 4; i++) begin
                a_mem[kk][i] = a;
                b_mem[kk][i] = b;
            end
    endtask

    task automatic set_dir(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input bit s);
        dir_rows[0] = r0; dir_rows[1] = r1; dir_rows[2] = r2; dir_rows[3] = r3;
        for (int i = 0; i < 4; i++) dir_sat[i] = s;
    endtask

    // Output-side ready generator.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold_ready)     m_axis_tready = 1'b0;
            else if (rnd_ready) m_axis_tready = ($urandom_range(0, 99) < 60);
            else                m_axis_tready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output transfer; tracks done, sat_flag and stall stability.
    bit          prev_last = 0;
    bit          exp_sat   = 0;
    bit          stalled   = 0;
    logic [31:0] stall_dat = '0;
    exp_t        got;

    always @(negedge clk) begin
        if (rst) begin
            prev_last = 0;
            exp_sat   = 0;
            stalled   = 0;
        end else begin
            check("done_pulse", done, prev_last);
            check("sat_flag", sat_flag, exp_sat);
            if (m_axis_tvalid) check("s_tready_in_drain", s_axis_tready, 0);
            if (stalled) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, stall_dat);
            end
            prev_last = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                stalled = 0;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_row: got %0h, expected no output", m_axis_tdata);
                end else begin
                    got = exp_q.pop_front();
                    check("row_data", m_axis_tdata, got.dat);
                    check("row_last", m_axis_tlast, got.last);
                    exp_sat   = exp_sat | got.sat;
                    prev_last = got.last;
                end
            end else if (m_axis_tvalid) begin
                stalled   = 1;
                stall_dat = m_axis_tdata;
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        cfg_shift = '0; cfg_relu_en = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat_flag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_tready", s_axis_tready, 1);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;

        // 1: K=1, 2*3 everywhere
        fill_const(1, 2, 3);
        set_dir(32'h06060606, 32'h06060606, 32'h06060606, 32'h06060606, 0);
        run_job(1, 0, 0, 0, 1);
        wait_idle();

        // 2: K=4, -1*100 summed to -400; ReLU then saturation
        fill_const(4, -1, 100);
        set_dir(32'h0, 32'h0, 32'h0, 32'h0, 0);
        run_job(4, 0, 1, 0, 1);
        wait_idle();
        set_dir(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 1);
        run_job(4, 0, 0, 0, 1);
        wait_idle();
        check("sat_sticky", sat_flag, 1);

        // 3: rounding with shift=2 (6->2, -6->-1, 5->1, 1->0)
        fill_const(1, 0, 1);
        a_mem[0][0] = 6; a_mem[0][1] = -6; a_mem[0][2] = 5; a_mem[0][3] = 1;
        set_dir(32'h02020202, 32'hFFFFFFFF, 32'h01010101, 32'h00000000, 0);
        run_job(1, 2, 0, 0, 1);
        wait_idle();

        // 4: random jobs with input gaps and output backpressure
        rnd_ready = 1;
        for (int n = 0; n < 20; n++) begin
            int k;
            k = int'($urandom_range(1, 6));
            fill_rand(k);
            run_job(k, int'($urandom_range(0, 10)), 1'($urandom), 1, 0);
            wait_idle();
        end
        rnd_ready = 0;

        // 5a: reset mid-ACCUM
        fill_rand(2);
        cfg_shift = 5'd3; cfg_relu_en = 1'b0;
        send_beat(beat_dat(0), 0);
        send_beat(beat_dat(1), 0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_accum_tvalid", m_axis_tvalid, 0);
        check("rst_accum_busy", busy, 0);
        @(posedge clk); #1;
        fill_rand(1);
        run_job(1, 4, 0, 0, 0);
        wait_idle();

        // 5b: reset mid-DRAIN
        hold_ready = 1;
        fill_rand(2);
        run_job(2, 1, 0, 0, 0);
        t = 0;
        while (!m_axis_tvalid && t < 100) begin @(negedge clk); t++; end
        check("drain_reached", m_axis_tvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        hold_ready = 0;
        @(negedge clk);
        check("rst_drain_tvalid", m_axis_tvalid, 0);
        check("rst_drain_busy", busy, 0);
        @(posedge clk); #1;
        fill_rand(1);
        run_job(1, 0, 1, 0, 0);
        wait_idle();

        // 6: back-to-back jobs (cfg scrambled during each DRAIN), then K=512 wrap to -2^23
        rnd_ready = 1;
        for (int n = 0; n < 6; n++) begin
            int k;
            k = int'($urandom_range(1, 4));
            wait_idle();
            fill_rand(k);
            run_job(k, int'($urandom_range(0, 8)), 1'($urandom), 0, 0);
        end
        wait_idle();
        fill_const(512, -128, -128);
        set_dir(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 0);
        run_job(512, 16, 0, 0, 1);
        wait_idle();
        rnd_ready = 0;

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
